ulpi_reg_arbiter: RTL and testbench
===================================

// Module: ulpi_reg_arbiter
//
// PURPOSE
//   Shares the ULPI link command port between NREQ register-access requesters.
//   Turns each granted request into a PHY register write (TX CMD 8'b10aaaaaa + data byte)
//   or read (TX CMD 8'b11aaaaaa, then capture the turnaround data byte).
//   Sits between config/software masters and the ULPI link.
//   Also snoops the raw PHY dir/nxt/data pins to collect read data.
//
// PARAMETERS
//   NREQ          2     number of requesters (1..4)
//   ROUND_ROBIN   1     1: rotate priority after each grant; 0: fixed, lowest index wins
//   TIMEOUT       255   cycles allowed per transaction phase before aborting with err
//   MAX_RETRY     3     restarts allowed when PHY takes the bus mid-write
//
// PORTS
//   clk         in   1        ULPI 60 MHz clock
//   reset_n     in   1        asynchronous active-low reset
//   req_valid   in   NREQ     request pending; held until matching req_done
//   req_we      in   NREQ     1 = write, 0 = read
//   req_addr    in   NREQ*6   register address, requester i at [6i+5:6i]
//   req_wdata   in   NREQ*8   write data, requester i at [8i+7:8i]
//   req_done    out  NREQ     one-cycle completion pulse to granted requester
//   req_err     out  1        valid with req_done: 1 = timeout / retry limit / bad addr
//   rsp_rdata   out  8        read data, valid with req_done (reads only)
//   lnk_cmd     out  8        byte to link command port
//   lnk_strobe  out  1        byte on lnk_cmd is offered
//   lnk_busy    in   1        link cannot accept; byte accepted when strobe && !busy
//   phy_dir     in   1        snooped ULPI dir
//   phy_nxt     in   1        snooped ULPI nxt
//   phy_data    in   8        snooped ULPI data
//
// BEHAVIOUR
//   Reset: state IDLE; req_done=0, req_err=0, rsp_rdata=0, lnk_cmd=0, lnk_strobe=0,
//     rr pointer=0, retry=0, timer=0.
//   All outputs registered. Accept = lnk_strobe && !lnk_busy, sampled at clk edge.
//   States:
//   - IDLE: pick grant from req_valid.
//     - RR: first set bit at/after pointer; pointer <= grant+1 (mod NREQ) on grant.
//     - Fixed: lowest index.
//     - Latch we/addr/wdata; retry=0.
//     - addr==6'h2F (extended) -> DONE with err=1; no link traffic.
//     - Else -> SEND_CMD.
//   - SEND_CMD: lnk_cmd = {1'b1, we?1'b0:1'b1, addr}, strobe=1.
//     - On accept: write -> SEND_DATA; read -> WAIT_TURN with strobe dropped.
//   - SEND_DATA: lnk_cmd = wdata, strobe=1.
//     - On accept: strobe=0 -> WAIT_STP; link issues stp on next nxt.
//     - phy_dir rising before accept: strobe=0, retry++ -> WAIT_IDLE_BUS.
//       retry > MAX_RETRY -> DONE err=1.
//   - WAIT_STP: strobe=0; -> DONE (err=0) first cycle lnk_busy==0 && phy_dir==0.
//   - WAIT_IDLE_BUS: wait phy_dir==0 && lnk_busy==0, then -> SEND_CMD (full reissue).
//   - WAIT_TURN: wait phy_dir 0->1 (turnaround cycle). Next cycle, if phy_dir==1 &&
//     phy_nxt==0: rsp_rdata <= phy_data -> DONE.
//     - phy_nxt==1 on that cycle: PHY aborted the read for RX; treat as retry
//       (-> WAIT_IDLE_BUS).
//   - DONE: req_done[grant]=1 for one cycle, req_err as set -> IDLE.
//     No new grant in the DONE cycle.
//   Timer: cleared on every state change; increments otherwise in non-IDLE states.
//     Reaching TIMEOUT -> strobe=0, DONE err=1.
//   req_valid dropping mid-transaction is ignored; the transaction completes.
//   Simultaneous requests: exactly one granted; the others wait, not lost.
//   Reset mid-transaction: immediate return to reset values; no done pulse.
//
// STRUCTURE
//   ulpi_pkg:
//     - UlpiCmd enum additions REG_WRITE=8'h80, REG_READ=8'hC0, EXT_ADDR=6'h2F
//     - state enum typedef
//   Sub-module ulpi_rr_arbiter (NREQ-wide round-robin/fixed grant, pointer register).
//   Sequencer FSM and timer live in this module.
//
// TESTING
//   1. Req0 write addr 0x0A data 0x55, link model accepts each byte immediately
//      -> lnk_cmd 0x8A then 0x55 on consecutive accepts; req_done[0] pulse, err=0.
//   2. Req1 read addr 0x04, PHY model raises dir 2 cycles after accept, data 0xA3 nxt=0
//      -> rsp_rdata=0xA3 with req_done[1], err=0.
//   3. req_valid=2'b11 held, ROUND_ROBIN=1 -> grants 0,1,0,1; ROUND_ROBIN=0 -> 0,0,0.
//   4. phy_dir rises while 0x55 offered (busy held)
//      -> strobe drops, 0x8A reissued after dir falls.
//      MAX_RETRY+1 such aborts -> done with err=1.
//   5. Read with PHY never asserting dir, TIMEOUT=16 -> done err=1 ~16 cycles after
//      cmd accept; strobe low.
//   6. Addr 0x2F -> done err=1 within 2 cycles, lnk_strobe never asserted.
//      Also: reset_n low mid SEND_DATA -> all outputs 0 at once, no req_done.

Source files
------------

// File: rtl/ulpi_reg_arbiter_pkg.sv
// rtl/ulpi_reg_arbiter_pkg.sv - shared types and constants for the ULPI register arbiter
//
// Purpose: ULPI TX CMD encodings, the extended-register address that this block
//          refuses, the sequencer state type and a TX CMD builder.
// Ports:   none (package).
package ulpi_reg_arbiter_pkg;

    typedef enum logic [7:0] {
        REG_WRITE = 8'h80,
        REG_READ  = 8'hC0
    } ulpi_cmd_e;

    // Extended register access needs a second address byte; not supported here.
    localparam logic [5:0] EXT_ADDR = 6'h2F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_SEND_DATA,
        ST_WAIT_STP,
        ST_WAIT_IDLE_BUS,
        ST_WAIT_TURN,
        ST_WAIT_DATA,
        ST_DONE
    } arb_state_e;

    function automatic logic [7:0] reg_cmd(input logic we, input logic [5:0] addr);
        logic [7:0] base;
        base = we ? REG_WRITE : REG_READ;
        return base | {2'b00, addr};
    endfunction

endpackage

// File: rtl/ulpi_reg_arbiter_if.sv
// rtl/ulpi_reg_arbiter_if.sv - requester, link command and PHY snoop signal bundle
//
// Purpose: groups the requester bus, the link command port and the snooped PHY pins.
// Ports:   req_valid/req_we/req_addr/req_wdata (requesters -> arbiter),
//          req_done/req_err/rsp_rdata (arbiter -> requesters),
//          lnk_cmd/lnk_strobe (arbiter -> link), lnk_busy (link -> arbiter),
//          phy_dir/phy_nxt/phy_data (PHY pins, snooped).
//          slave modport: arbiter side; master modport: requester/link/PHY side.
interface ulpi_reg_arbiter_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*6-1:0] req_addr;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   req_done;
    logic              req_err;
    logic [7:0]        rsp_rdata;
    logic [7:0]        lnk_cmd;
    logic              lnk_strobe;
    logic              lnk_busy;
    logic              phy_dir;
    logic              phy_nxt;
    logic [7:0]        phy_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, lnk_busy, phy_dir, phy_nxt, phy_data,
        output req_done, req_err, rsp_rdata, lnk_cmd, lnk_strobe
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, lnk_busy, phy_dir, phy_nxt, phy_data,
        input  req_done, req_err, rsp_rdata, lnk_cmd, lnk_strobe
    );
endinterface

// File: rtl/ulpi_reg_arbiter_rr.sv
// rtl/ulpi_reg_arbiter_rr.sv - NREQ-wide round-robin / fixed-priority grant selector
//
// Purpose: picks one pending requester. Round-robin searches from the pointer
//          upwards and moves the pointer past the winner when the grant is taken;
//          fixed mode always prefers the lowest index.
// Ports:   clk, reset_n; req (pending vector); take (grant consumed this cycle);
//          gnt_any (some request pending); gnt_idx (winning index).
module ulpi_reg_arbiter_rr #(
    parameter int NREQ        = 2,
    parameter int ROUND_ROBIN = 1,
    localparam int GW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic            gnt_any,
    output logic [GW-1:0]   gnt_idx
);

    logic [GW-1:0] ptr_q, ptr_d;

    always_comb begin
        int cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (ROUND_ROBIN != 0) ? (int'(ptr_q) + off) % NREQ : off;
            for (int i = 0; i < NREQ; i++) begin
                if (i == cand && req[i] && !gnt_any) begin
                    gnt_any = 1'b1;
                    gnt_idx = GW'(i);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (ROUND_ROBIN != 0 && take && gnt_any)
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + GW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// rtl/ulpi_reg_arbiter.sv - shares the ULPI link command port between register requesters
//
// Purpose: grants one requester at a time and turns its request into a ULPI
//          register write (TX CMD + data byte) or read (TX CMD, then the byte
//          captured after the bus turnaround). Per-phase timeout and bounded
//          restarts when the PHY grabs the bus mid-write.
// Ports:   clk, reset_n (async, active low); bus (ulpi_reg_arbiter_if.slave):
//          requester handshake, link command port, snooped PHY dir/nxt/data.
module ulpi_reg_arbiter
    import ulpi_reg_arbiter_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    ulpi_reg_arbiter_if.slave  bus
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            we_q, we_d;
    logic [5:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            dir_prev_q, dir_prev_d;
    logic [7:0]      lnk_cmd_q, lnk_cmd_d;
    logic            lnk_strobe_q, lnk_strobe_d;
    logic [NREQ-1:0] req_done_q, req_done_d;
    logic            req_err_q, req_err_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;

    logic            gnt_any;
    logic [GW-1:0]   gnt_idx;
    logic            take;
    logic            accept;
    logic            we_sel;
    logic [5:0]      addr_sel;
    logic [7:0]      wdata_sel;

    ulpi_reg_arbiter_rr #(
        .NREQ        (NREQ),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .take    (take),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    assign accept = lnk_strobe_q && !bus.lnk_busy;

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == GW'(i)) begin
                we_sel    = bus.req_we[i];
                addr_sel  = bus.req_addr[6*i +: 6];
                wdata_sel = bus.req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        logic finish;
        logic finish_err;
        logic phy_abort;

        state_d      = state_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        retry_d      = retry_q;
        timer_d      = '0;
        dir_prev_d   = bus.phy_dir;
        lnk_cmd_d    = lnk_cmd_q;
        lnk_strobe_d = lnk_strobe_q;
        req_done_d   = '0;
        req_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        take         = 1'b0;
        finish       = 1'b0;
        finish_err   = 1'b0;
        phy_abort    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    take    = 1'b1;
                    grant_d = gnt_idx;
                    we_d    = we_sel;
                    addr_d  = addr_sel;
                    wdata_d = wdata_sel;
                    retry_d = '0;
                    if (addr_sel == EXT_ADDR) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else begin
                        state_d      = ST_SEND_CMD;
                        lnk_cmd_d    = reg_cmd(we_sel, addr_sel);
                        lnk_strobe_d = 1'b1;
                    end
                end
            end
            ST_SEND_CMD: begin
                if (accept) begin
                    if (we_q) begin
                        state_d   = ST_SEND_DATA;
                        lnk_cmd_d = wdata_q;
                    end else begin
                        state_d      = ST_WAIT_TURN;
                        lnk_strobe_d = 1'b0;
                    end
                end
            end
            ST_SEND_DATA: begin
                // dir high means the PHY owns the bus; the link will never take the byte.
                if (accept) begin
                    state_d      = ST_WAIT_STP;
                    lnk_strobe_d = 1'b0;
                end else if (bus.phy_dir) begin
                    phy_abort = 1'b1;
                end
            end
            ST_WAIT_STP: begin
                if (!bus.lnk_busy && !bus.phy_dir) finish = 1'b1;
            end
            ST_WAIT_IDLE_BUS: begin
                if (!bus.phy_dir && !bus.lnk_busy) begin
                    state_d      = ST_SEND_CMD;
                    lnk_cmd_d    = reg_cmd(we_q, addr_q);
                    lnk_strobe_d = 1'b1;
                end
            end
            ST_WAIT_TURN: begin
                if (bus.phy_dir && !dir_prev_q) state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                // Cycle after turnaround: nxt high means the PHY switched to an RX packet.
                if (bus.phy_dir && !bus.phy_nxt) begin
                    rsp_rdata_d = bus.phy_data;
                    finish      = 1'b1;
                end else begin
                    phy_abort = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (phy_abort) begin
            lnk_strobe_d = 1'b0;
            retry_d      = retry_q + RW'(1);
            if (int'(retry_q) >= MAX_RETRY) begin
                finish     = 1'b1;
                finish_err = 1'b1;
            end else begin
                state_d = ST_WAIT_IDLE_BUS;
            end
        end

        if (state_q != ST_IDLE && state_q != ST_DONE && state_d == state_q) begin
            if (int'(timer_q) >= TIMEOUT - 1) begin
                finish     = 1'b1;
                finish_err = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        if (finish) begin
            state_d      = ST_DONE;
            lnk_strobe_d = 1'b0;
            req_err_d    = finish_err;
            timer_d      = '0;
            for (int i = 0; i < NREQ; i++) req_done_d[i] = (grant_d == GW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            retry_q      <= '0;
            timer_q      <= '0;
            dir_prev_q   <= 1'b0;
            lnk_cmd_q    <= '0;
            lnk_strobe_q <= 1'b0;
            req_done_q   <= '0;
            req_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            dir_prev_q   <= dir_prev_d;
            lnk_cmd_q    <= lnk_cmd_d;
            lnk_strobe_q <= lnk_strobe_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign bus.req_done   = req_done_q;
    assign bus.req_err    = req_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.lnk_cmd    = lnk_cmd_q;
    assign bus.lnk_strobe = lnk_strobe_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// tb/tb_ulpi_reg_arbiter.sv - scoreboard bench for ulpi_reg_arbiter
module tb_ulpi_reg_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ulpi_reg_arbiter_if #(.NREQ(2)) bus ();
    ulpi_reg_arbiter_if #(.NREQ(2)) bus_b ();

    ulpi_reg_arbiter #(.NREQ(2), .ROUND_ROBIN(1), .TIMEOUT(16), .MAX_RETRY(3)) dut_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    ulpi_reg_arbiter #(.NREQ(2), .ROUND_ROBIN(0), .TIMEOUT(16), .MAX_RETRY(3)) dut_fx (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b.slave)
    );

    typedef struct {
        logic [1:0] done;
        logic       err;
        bit         chk_rd;
        logic [7:0] rd;
    } exp_t;

    exp_t       exp_done_q[$];
    logic [7:0] exp_lnk_q[$];
    logic [1:0] exp_b_q[$];
    exp_t       e;
    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int strobe_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [5:0] addr, input logic [7:0] wd);
        bus.req_we[i]          = we;
        bus.req_addr[6*i +: 6] = addr;
        bus.req_wdata[8*i +: 8] = wd;
    endtask

    task automatic wait_accept(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.lnk_strobe && !bus.lnk_busy) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s accept_timeout got=none required=accept", name);
        end
        tick();
    endtask

    task automatic wait_done(input string name, output int cycles, output logic stb);
        bit ok;
        ok = 1'b0; cycles = 0; stb = 1'b0;
        while (!ok && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (bus.req_done != '0) begin ok = 1'b1; stb = bus.lnk_strobe; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s done_timeout got=none required=req_done", name);
        end
        tick();
    endtask

    task automatic wait_done_b(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus_b.req_done != '0) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL %s done_timeout got=none required=req_done", name);
        end
        tick();
    endtask

    // Scoreboard monitor for the round-robin instance.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.lnk_strobe) strobe_cnt++;
            if (bus.lnk_strobe && !bus.lnk_busy) begin
                if (exp_lnk_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL lnk_unexpected got=%02h required=no_accept", bus.lnk_cmd);
                end else begin
                    check("lnk_cmd", {24'h0, bus.lnk_cmd}, {24'h0, exp_lnk_q.pop_front()});
                end
            end
            if (bus.req_done != '0) begin
                done_seen++;
                if (exp_done_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected got=%0b required=none", bus.req_done);
                end else begin
                    e = exp_done_q.pop_front();
                    check("done_vec", {30'h0, bus.req_done}, {30'h0, e.done});
                    check("done_err", {31'h0, bus.req_err}, {31'h0, e.err});
                    if (e.chk_rd) check("rsp_rdata", {24'h0, bus.rsp_rdata}, {24'h0, e.rd});
                end
            end
        end
    end

    // Grant-order monitor for the fixed-priority instance.
    always @(negedge clk) begin
        if (reset_n && bus_b.req_done != '0) begin
            if (exp_b_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL fx_done_unexpected got=%0b required=none", bus_b.req_done);
            end else begin
                check("fx_done_vec", {30'h0, bus_b.req_done}, {30'h0, exp_b_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        logic stb;

        bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.lnk_busy = 1'b0; bus.phy_dir = 1'b0; bus.phy_nxt = 1'b0; bus.phy_data = '0;
        bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
        bus_b.lnk_busy = 1'b0; bus_b.phy_dir = 1'b0; bus_b.phy_nxt = 1'b0; bus_b.phy_data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_strobe", {31'h0, bus.lnk_strobe}, 32'h0);
        check("reset_cmd", {24'h0, bus.lnk_cmd}, 32'h0);
        check("reset_done", {30'h0, bus.req_done}, 32'h0);
        check("reset_err", {31'h0, bus.req_err}, 32'h0);
        check("reset_rdata", {24'h0, bus.rsp_rdata}, 32'h0);
        reset_n = 1'b1;
        tick();

        // 1: write req0 addr 0x0A data 0x55
        exp_lnk_q.push_back(8'h8A); exp_lnk_q.push_back(8'h55);
        exp_done_q.push_back('{done: 2'b01, err: 1'b0, chk_rd: 1'b0, rd: 8'h00});
        set_req(0, 1'b1, 6'h0A, 8'h55);
        bus.req_valid = 2'b01;
        wait_done("t1", lat, stb);
        bus.req_valid = 2'b00;

        // 2: read req1 addr 0x04, PHY returns 0xA3
        exp_lnk_q.push_back(8'hC4);
        exp_done_q.push_back('{done: 2'b10, err: 1'b0, chk_rd: 1'b1, rd: 8'hA3});
        set_req(1, 1'b0, 6'h04, 8'h00);
        bus.req_valid = 2'b10;
        wait_accept("t2");
        tick(); tick();
        bus.phy_dir = 1'b1;
        tick();
        bus.phy_data = 8'hA3; bus.phy_nxt = 1'b0;
        tick();
        bus.phy_dir = 1'b0; bus.phy_data = 8'h00;
        wait_done("t2", lat, stb);
        bus.req_valid = 2'b00;

        // 3: both held, round robin 0,1,0,1
        set_req(0, 1'b1, 6'h01, 8'h11);
        set_req(1, 1'b1, 6'h02, 8'h22);
        for (int k = 0; k < 2; k++) begin
            exp_lnk_q.push_back(8'h81); exp_lnk_q.push_back(8'h11);
            exp_done_q.push_back('{done: 2'b01, err: 1'b0, chk_rd: 1'b0, rd: 8'h00});
            exp_lnk_q.push_back(8'h82); exp_lnk_q.push_back(8'h22);
            exp_done_q.push_back('{done: 2'b10, err: 1'b0, chk_rd: 1'b0, rd: 8'h00});
        end
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) wait_done("t3", lat, stb);
        bus.req_valid = 2'b00;

        // 3b: fixed priority keeps granting requester 0
        bus_b.req_we = 2'b11; bus_b.req_addr = {6'h02, 6'h01}; bus_b.req_wdata = {8'h22, 8'h11};
        for (int k = 0; k < 3; k++) exp_b_q.push_back(2'b01);
        bus_b.req_valid = 2'b11;
        for (int k = 0; k < 3; k++) wait_done_b("t3_fixed");
        bus_b.req_valid = 2'b00;

        // 4: PHY takes the bus while 0x55 is offered, MAX_RETRY+1 times
        set_req(0, 1'b1, 6'h0A, 8'h55);
        for (int k = 0; k < 4; k++) exp_lnk_q.push_back(8'h8A);
        exp_done_q.push_back('{done: 2'b01, err: 1'b1, chk_rd: 1'b0, rd: 8'h00});
        bus.req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            wait_accept("t4");
            bus.lnk_busy = 1'b1;
            tick();
            check("t4_offer", {23'h0, bus.lnk_strobe, bus.lnk_cmd}, 32'h155);
            bus.phy_dir = 1'b1;
            tick();
            check("t4_abort_strobe", {31'h0, bus.lnk_strobe}, 32'h0);
            bus.phy_dir = 1'b0; bus.lnk_busy = 1'b0;
        end
        wait_done("t4", lat, stb);
        bus.req_valid = 2'b00;

        // 5: read with PHY silent -> timeout
        set_req(0, 1'b0, 6'h10, 8'h00);
        exp_lnk_q.push_back(8'hD0);
        exp_done_q.push_back('{done: 2'b01, err: 1'b1, chk_rd: 1'b0, rd: 8'h00});
        bus.req_valid = 2'b01;
        wait_accept("t5");
        wait_done("t5", lat, stb);
        bus.req_valid = 2'b00;
        check("t5_latency_in_range", {31'h0, (lat >= 15 && lat <= 19)}, 32'h1);
        check("t5_strobe_at_done", {31'h0, stb}, 32'h0);

        // 6: extended address refused without link traffic
        seen = strobe_cnt;
        set_req(1, 1'b1, 6'h2F, 8'h77);
        exp_done_q.push_back('{done: 2'b10, err: 1'b1, chk_rd: 1'b0, rd: 8'h00});
        bus.req_valid = 2'b10;
        wait_done("t6", lat, stb);
        bus.req_valid = 2'b00;
        check("t6_latency_le2", {31'h0, (lat <= 2)}, 32'h1);
        check("t6_no_strobe", strobe_cnt, seen);

        // 7: reset in the middle of SEND_DATA
        set_req(0, 1'b1, 6'h0A, 8'h55);
        exp_lnk_q.push_back(8'h8A);
        bus.req_valid = 2'b01;
        wait_accept("t7");
        bus.lnk_busy = 1'b1;
        tick();
        check("t7_offer", {23'h0, bus.lnk_strobe, bus.lnk_cmd}, 32'h155);
        seen = done_seen;
        reset_n = 1'b0;
        #1;
        check("t7_rst_strobe", {31'h0, bus.lnk_strobe}, 32'h0);
        check("t7_rst_cmd", {24'h0, bus.lnk_cmd}, 32'h0);
        check("t7_rst_rdata", {24'h0, bus.rsp_rdata}, 32'h0);
        check("t7_rst_done", {30'h0, bus.req_done}, 32'h0);
        bus.req_valid = 2'b00; bus.lnk_busy = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("t7_no_done", done_seen, seen);

        check("sb_lnk_empty", exp_lnk_q.size(), 0);
        check("sb_done_empty", exp_done_q.size(), 0);
        check("sb_fx_empty", exp_b_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
